multiply_add: RTL and testbench

//  Clocked inverse of the divider: rebuilds the dividend as p = s*b + mod with
//  a shift-add loop, one bit of s per cycle, so divide results can be checked

---
 rtl/multiply_add_pkg.sv | 20 ++
 rtl/multiply_add_shift_add_unit.sv | 53 +++++
 rtl/multiply_add.sv | 114 +++++++++++
 tb/tb_multiply_add.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/multiply_add_pkg.sv
// Shared types and sizing helpers for the multiply_add block.
// Holds the FSM state enum, default widths and the counter-width helper.
package multiply_add_pkg;

  localparam int AWidthDef = 32;
  localparam int BWidthDef = 32;
  localparam int PWidth    = AWidthDef + BWidthDef;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must be able to hold the value AWidth itself.
  function automatic int cnt_width(input int aw);
    return $clog2(aw + 1);
  endfunction

endpackage

// File: rtl/multiply_add_shift_add_unit.sv
// Shift-add datapath: accumulator, shifting multiplier and multiplicand.
// Ports: clk, rst_n, load, step, s, b, mod in; acc_next, s_next out.
module shift_add_unit
  import multiply_add_pkg::*;
#(
  parameter int AWidth = AWidthDef,
  parameter int BWidth = BWidthDef
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic                     step,
  input  logic [AWidth-1:0]        s,
  input  logic [BWidth-1:0]        b,
  input  logic [BWidth-1:0]        mod,
  output logic [AWidth+BWidth-1:0] acc_next,
  output logic [AWidth-1:0]        s_next
);

  localparam int PW = AWidth + BWidth;

  logic [PW-1:0]     acc;
  logic [PW-1:0]     b_r;
  logic [PW-1:0]     b_next;
  logic [AWidth-1:0] s_r;

  // PW bits hold (2^A-1)(2^B-1)+(2^B-1) < 2^PW, so no carry is lost.
  always_comb begin
    acc_next = acc;
    if (s_r[0]) begin
      acc_next = acc + b_r;
    end
    s_next = s_r >> 1;
    b_next = b_r << 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      b_r <= '0;
      s_r <= '0;
    end else if (load) begin
      acc <= {{AWidth{1'b0}}, mod};
      b_r <= {{AWidth{1'b0}}, b};
      s_r <= s;
    end else if (step) begin
      acc <= acc_next;
      b_r <= b_next;
      s_r <= s_next;
    end
  end

endmodule

// File: rtl/multiply_add.sv
// Multi-cycle p = s*b + mod with a four-phase req/fin handshake.
// Ports: clk, rst_n, req, s, b, mod in; fin, p, ovf out.
// Option: define MULTIPLY_ADD_EARLY_EXIT_EN to stop once s_r runs out.
module multiply_add
  import multiply_add_pkg::*;
#(
  parameter int AWidth = AWidthDef,
  parameter int BWidth = BWidthDef
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req,
  input  logic [AWidth-1:0]        s,
  input  logic [BWidth-1:0]        b,
  input  logic [BWidth-1:0]        mod,
  output logic                     fin,
  output logic [AWidth+BWidth-1:0] p,
  output logic                     ovf
);

  localparam int PW = AWidth + BWidth;
  localparam int CW = cnt_width(AWidth);

  state_t            state;
  state_t            state_d;
  logic [CW-1:0]     cnt;
  logic              load;
  logic              step;
  logic              last;
  logic              finish;
  logic [PW-1:0]     acc_next;
  logic [AWidth-1:0] s_next;

  shift_add_unit #(
    .AWidth (AWidth),
    .BWidth (BWidth)
  ) u_unit (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .step     (step),
    .s        (s),
    .b        (b),
    .mod      (mod),
    .acc_next (acc_next),
    .s_next   (s_next)
  );

  // Final RUN edge: counter about to reach AWidth,
  // or (optionally) no multiplier bits left to add.
  always_comb begin
`ifdef MULTIPLY_ADD_EARLY_EXIT_EN
    last = (cnt == CW'(AWidth - 1)) || (s_next == '0);
`else
    last = (cnt == CW'(AWidth - 1));
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (req) state_d = RUN;
      RUN:  if (last) state_d = DONE;
      DONE: if (!req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load   = 1'b0;
    step   = 1'b0;
    finish = 1'b0;
    fin    = 1'b0;
    unique case (1'b1)
      (state == IDLE): load = req;
      (state == RUN): begin
        step   = 1'b1;
        finish = last;
      end
      (state == DONE): fin = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Result registers survive the return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p   <= '0;
      ovf <= 1'b0;
    end else if (finish) begin
      p   <= acc_next;
      ovf <= |acc_next[PW-1:AWidth];
    end
  end

endmodule

// File: tb/tb_multiply_add.sv
// Self-checking bench for multiply_add at AWidth=8, BWidth=8.
// Behavioural model plus per-cycle compare and literal spot checks.
module tb_multiply_add;

  localparam int AW = 8;
  localparam int BW = 8;
  localparam int PW = AW + BW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic [AW-1:0] s = '0;
  logic [BW-1:0] b = '0;
  logic [BW-1:0] mod = '0;
  logic          fin;
  logic [PW-1:0] p;
  logic          ovf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multiply_add #(
    .AWidth (AW),
    .BWidth (BW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .s     (s),
    .b     (b),
    .mod   (mod),
    .fin   (fin),
    .p     (p),
    .ovf   (ovf)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Edges from the sampling edge (counted as 1) until fin is high.
  function automatic int lat(input logic [AW-1:0] sv);
`ifdef MULTIPLY_ADD_EARLY_EXIT_EN
    for (int i = AW - 1; i >= 0; i--) begin
      if (sv[i]) return i + 2;
    end
    return 2;
`else
    return AW + 1;
`endif
  endfunction

  // Behavioural model: protocol level, result by plain arithmetic.
  int            m_left = 0;
  bit            m_busy = 0;
  logic          m_fin = 1'b0;
  logic [PW-1:0] m_p = '0;
  logic          m_ovf = 1'b0;
  logic [AW-1:0] ls;
  logic [BW-1:0] lb;
  logic [BW-1:0] lm;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_busy = 0;
      m_fin  = 1'b0;
      m_p    = '0;
      m_ovf  = 1'b0;
    end else if (m_fin) begin
      if (!req) m_fin = 1'b0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0;
        m_fin  = 1'b1;
        m_p    = PW'(ls) * PW'(lb) + PW'(lm);
        m_ovf  = (m_p[PW-1:AW] != '0);
      end
    end else if (req) begin
      ls     = s;
      lb     = b;
      lm     = mod;
      m_busy = 1;
      m_left = lat(s) - 1;
    end
  end

  always @(negedge clk) begin
    check("fin", 32'(fin), 32'(m_fin));
    check("p", 32'(p), 32'(m_p));
    check("ovf", 32'(ovf), 32'(m_ovf));
  end

  // One operation. drop_at: RUN cycle where req falls (0 = none).
  // hold: keep req high 3 extra edges after fin.
  task automatic op(input logic [AW-1:0] sv, input logic [BW-1:0] bv,
                    input logic [BW-1:0] mv, input int drop_at,
                    input bit hold, output int latency);
    @(negedge clk);
    s   = sv;
    b   = bv;
    mod = mv;
    req = 1'b1;
    @(posedge clk);
    latency = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (fin) break;
      if (k + 1 == drop_at) req = 1'b0;
      s   = AW'($urandom);
      b   = BW'($urandom);
      mod = BW'($urandom);
      @(posedge clk);
      latency++;
    end
    if (!fin) check("fin_timeout", 32'(fin), 32'd1);
    if (hold) begin
      repeat (3) @(negedge clk);
      check("fin_hold", 32'(fin), 32'd1);
    end
    req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("fin_fall", 32'(fin), 32'd0);
  endtask

  int l;
  int a;
  int bv;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_fin", 32'(fin), 32'd0);
    check("rst_p", 32'(p), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;

    op(8'd13, 8'd7, 8'd3, 0, 0, l);
    check("t1_p", 32'(p), 32'd94);
    check("t1_ovf", 32'(ovf), 32'd0);
`ifdef MULTIPLY_ADD_EARLY_EXIT_EN
    check("t1_lat", 32'(l), 32'd5);
`else
    check("t1_lat", 32'(l), 32'd9);
`endif

    op(8'd255, 8'd255, 8'd254, 0, 0, l);
    check("t2a_p", 32'(p), 32'd65279);
    check("t2a_ovf", 32'(ovf), 32'd1);
    op(8'd1, 8'd200, 8'd55, 0, 0, l);
    check("t2b_p", 32'(p), 32'd255);
    check("t2b_ovf", 32'(ovf), 32'd0);

    op(8'd200, 8'd100, 8'd17, 4, 0, l);
    check("t3a_p", 32'(p), 32'd20017);
    check("t3a_ovf", 32'(ovf), 32'd1);
    op(8'd9, 8'd11, 8'd2, 0, 1, l);
    check("t3b_p", 32'(p), 32'd101);

    @(negedge clk);
    s   = 8'd77;
    b   = 8'd33;
    mod = 8'd5;
    req = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t4_fin", 32'(fin), 32'd0);
    check("t4_p", 32'(p), 32'd0);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    op(8'd77, 8'd33, 8'd5, 0, 0, l);
    check("t4_p2", 32'(p), 32'd2546);

    op(8'd0, 8'd45, 8'd9, 0, 0, l);
    check("t5a_p", 32'(p), 32'd9);
`ifdef MULTIPLY_ADD_EARLY_EXIT_EN
    check("t5a_lat", 32'(l), 32'd2);
`else
    check("t5a_lat", 32'(l), 32'd9);
`endif
    op(8'd1, 8'd45, 8'd9, 0, 0, l);
`ifdef MULTIPLY_ADD_EARLY_EXIT_EN
    check("t5b_lat", 32'(l), 32'd2);
`else
    check("t5b_lat", 32'(l), 32'd9);
`endif
    op(8'd128, 8'd45, 8'd9, 0, 0, l);
    check("t5c_lat", 32'(l), 32'd9);
    check("t5c_p", 32'(p), 32'd5769);

    for (int i = 0; i < 30; i++) begin
      op(AW'($urandom), BW'($urandom), BW'($urandom), 0, 0, l);
      check("rnd_lat", 32'(l), 32'(lat(ls)));
    end

    for (int i = 0; i < 1000; i++) begin
      a  = int'($urandom_range(0, 255));
      bv = int'($urandom_range(1, 255));
      op(AW'(a / bv), BW'(bv), BW'(a % bv), 0, 0, l);
      check("rt_p", 32'(p), 32'(a));
      check("rt_ovf", 32'(ovf), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
